i2c_slave_ctrl: RTL

- Control FSM that sequences the I2C slave datapath: start/stop detectors, SIPO shift register, register-pointer select, 32x8 register memory, SDA output generator and master-ACK sampler.
- Tracks the bit position within each byte and decodes address, register-pointer and data phases.
- Issues single-cycle load, increment and write strobes, aligned to synchronized SCL edge pulses.

---
 rtl/i2c_slave_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_ctrl.sv
// Control FSM for the I2C slave datapath: decodes address, register-pointer and
// data phases and issues load/increment/write strobes on synchronized SCL edges.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h20
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       SCL_posedge,
  input  logic       SCL_negedge,
  input  logic [7:0] data_in,
  input  logic       master_ack,
  output logic       clear_start,
  output logic       clear_stop,
  output logic       shift_en,
  output logic       sel_load,
  output logic       sel_inc,
  output logic       we,
  output logic [2:0] count,
  output logic       send_ack,
  output logic       out_en,
  output logic       busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(8);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             rw_q, rw_d;
  logic             clear_start_q, clear_start_d;
  logic             clear_stop_q, clear_stop_d;

  logic receiving;
  logic start_take;
  logic stop_take;
  logic byte_done;

  // Flags are masked while their clear pulse is in flight so one event is taken once.
  assign start_take = start & ~clear_start_q;
  assign stop_take  = stop & ~clear_stop_q;
  assign receiving  = (state_q == ADDR) || (state_q == REG) || (state_q == WRITE);
  assign byte_done  = SCL_negedge && (bit_cnt_q == CNT_FULL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= CNT_ZERO;
      rw_q          <= 1'b0;
      clear_start_q <= 1'b0;
      clear_stop_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rw_q          <= rw_d;
      clear_start_q <= clear_start_d;
      clear_stop_q  <= clear_stop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rw_d          = rw_q;
    clear_start_d = 1'b0;
    clear_stop_d  = 1'b0;
    sel_load      = 1'b0;
    sel_inc       = 1'b0;
    we            = 1'b0;

    if (stop_take) begin
      state_d      = IDLE;
      bit_cnt_d    = CNT_ZERO;
      rw_d         = 1'b0;
      clear_stop_d = 1'b1;
    end else if (start_take) begin
      state_d       = ADDR;
      bit_cnt_d     = CNT_ZERO;
      rw_d          = 1'b0;
      clear_start_d = 1'b1;
    end else begin
      if (receiving && SCL_posedge && (bit_cnt_q != CNT_FULL)) begin
        bit_cnt_d = bit_cnt_q + CNT_ONE;
      end
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (byte_done) begin
            if (data_in[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = data_in[0];
            end else begin
              state_d   = IDLE;
              bit_cnt_d = CNT_ZERO;
            end
          end
        end
        ADDR_ACK: begin
          if (SCL_negedge) begin
            bit_cnt_d = CNT_ZERO;
            state_d   = rw_q ? READ : REG;
          end
        end
        REG: begin
          if (byte_done) begin
            state_d  = REG_ACK;
            sel_load = 1'b1;
          end
        end
        REG_ACK: begin
          if (SCL_negedge) begin
            state_d   = WRITE;
            bit_cnt_d = CNT_ZERO;
          end
        end
        WRITE: begin
          if (byte_done) begin
            state_d = WRITE_ACK;
            we      = 1'b1;
          end
        end
        WRITE_ACK: begin
          if (SCL_negedge) begin
            state_d   = WRITE;
            bit_cnt_d = CNT_ZERO;
            sel_inc   = 1'b1;
          end
        end
        READ: begin
          // Transmit bits advance on the falling edge so count indexes the next bit out.
          if (SCL_negedge) begin
            if (bit_cnt_q == CNT_LAST) begin
              bit_cnt_d = CNT_FULL;
              state_d   = READ_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
          end
        end
        READ_ACK: begin
          if (SCL_negedge) begin
            bit_cnt_d = CNT_ZERO;
            if (master_ack) begin
              state_d = READ;
              sel_inc = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = CNT_ZERO;
        end
      endcase
    end
  end

  // Phase outputs decode the state register directly, so reset releases SDA at once.
  assign clear_start = clear_start_q;
  assign clear_stop  = clear_stop_q;
  assign shift_en    = receiving;
  assign send_ack    = (state_q == ADDR_ACK) || (state_q == REG_ACK) || (state_q == WRITE_ACK);
  assign out_en      = (state_q == READ);
  assign busy        = (state_q != IDLE);
  assign count       = bit_cnt_q[2:0];

endmodule
